// File: rtl/fa_tag_store.sv
// Fully-associative tag/data store with registered lookup and
// pseudo-LRU tracker interface (touch port out, victim index in).
module fa_tag_store #(
  parameter int ENTRIES = 8,
  parameter int TAG_W   = 27,
  parameter int DATA_W  = 44,
  localparam int IDX_W  = $clog2(ENTRIES),
  localparam int CNT_W  = IDX_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lookup_valid_i,
  input  logic [TAG_W-1:0]  lookup_tag_i,
  output logic              resp_valid_o,
  output logic              resp_hit_o,
  output logic [DATA_W-1:0] resp_data_o,
  input  logic              fill_valid_i,
  output logic              fill_ready_o,
  input  logic [TAG_W-1:0]  fill_tag_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              flush_i,
  output logic              access_hit_o,
  output logic [IDX_W-1:0]  access_idx_o,
  input  logic [IDX_W-1:0]  replacement_idx_i,
  output logic [CNT_W-1:0]  count_o
);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [DATA_W-1:0]  data_q [ENTRIES];
  logic [CNT_W-1:0]   count_q;

  logic [ENTRIES-1:0] lk_match, fl_match;
  logic [IDX_W-1:0]   lk_idx, dup_idx, free_idx, victim;
  logic               lk_any, dup_any, free_any;
  logic               fill_acc, lk_hit, grow;

  // Per-slot tag comparators for the lookup and the fill de-dup search.
  for (genvar g = 0; g < ENTRIES; g++) begin : g_cmp
    assign lk_match[g] = valid_q[g] && (tag_q[g] == lookup_tag_i);
    assign fl_match[g] = valid_q[g] && (tag_q[g] == fill_tag_i);
  end

  assign fill_ready_o = ~flush_i;
  assign fill_acc     = fill_valid_i & ~flush_i;

  // Lowest-index priority encoders (scan downward so the lowest set bit wins).
  always_comb begin
    lk_idx   = '0;
    dup_idx  = '0;
    free_idx = '0;
    lk_any   = |lk_match;
    dup_any  = |fl_match;
    free_any = ~&valid_q;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (lk_match[i]) lk_idx = IDX_W'(i);
      if (fl_match[i]) dup_idx = IDX_W'(i);
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  // A same-tag fill in the lookup cycle hides the slot until the next cycle,
  // so the lookup and the fill never both touch the tracker for one entry.
  assign lk_hit = lookup_valid_i & lk_any & ~flush_i &
                  ~(fill_acc & (fill_tag_i == lookup_tag_i));
  assign victim = dup_any ? dup_idx : (free_any ? free_idx : replacement_idx_i);
  assign grow   = fill_acc & ~dup_any & free_any;

  // Valid bits and occupancy count; flush wins over everything.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
      count_q <= '0;
    end else if (fill_acc) begin
      valid_q[victim] <= 1'b1;
      if (grow && count_q != CNT_W'(ENTRIES)) count_q <= count_q + 1'b1;
    end
  end

  // Tag/data storage, written on accepted fill; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (fill_acc) begin
      tag_q[victim]  <= fill_tag_i;
      data_q[victim] <= fill_data_i;
    end
  end

  // Registered lookup response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_valid_o <= 1'b0;
      resp_hit_o   <= 1'b0;
      resp_data_o  <= '0;
    end else begin
      resp_valid_o <= lookup_valid_i;
      resp_hit_o   <= lk_hit;
      resp_data_o  <= lk_hit ? data_q[lk_idx] : '0;
    end
  end

  // Tracker touch: lookup hit beats fill; index holds when idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      access_hit_o <= 1'b0;
      access_idx_o <= '0;
    end else if (lk_hit) begin
      access_hit_o <= 1'b1;
      access_idx_o <= lk_idx;
    end else if (fill_acc) begin
      access_hit_o <= 1'b1;
      access_idx_o <= victim;
    end else begin
      access_hit_o <= 1'b0;
    end
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_fa_tag_store.sv
// Scoreboard bench for fa_tag_store: a behavioural store model predicts
// each cycle's registered outputs, queued at drive time, popped one cycle later.
module tb_fa_tag_store;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        lookup_valid_i = 1'b0;
  logic [26:0] lookup_tag_i = '0;
  logic        resp_valid_o, resp_hit_o;
  logic [43:0] resp_data_o;
  logic        fill_valid_i = 1'b0;
  logic        fill_ready_o;
  logic [26:0] fill_tag_i = '0;
  logic [43:0] fill_data_i = '0;
  logic        flush_i = 1'b0;
  logic        access_hit_o;
  logic [2:0]  access_idx_o;
  logic [2:0]  replacement_idx_i = '0;
  logic [3:0]  count_o;

  fa_tag_store #(.ENTRIES(8), .TAG_W(27), .DATA_W(44)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lookup_valid_i(lookup_valid_i), .lookup_tag_i(lookup_tag_i),
    .resp_valid_o(resp_valid_o), .resp_hit_o(resp_hit_o), .resp_data_o(resp_data_o),
    .fill_valid_i(fill_valid_i), .fill_ready_o(fill_ready_o),
    .fill_tag_i(fill_tag_i), .fill_data_i(fill_data_i), .flush_i(flush_i),
    .access_hit_o(access_hit_o), .access_idx_o(access_idx_o),
    .replacement_idx_i(replacement_idx_i), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        rv;
    logic        rh;
    logic [43:0] rd;
    logic        ah;
    logic [2:0]  ai;
    logic [3:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  bit          m_valid [8];
  logic [26:0] m_tag   [8];
  logic [43:0] m_data  [8];
  int          m_count;
  logic [2:0]  m_aidx;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_valid[i] = 0;
    m_count = 0;
    m_aidx  = '0;
  endtask

  // One clock: drive, predict, push; then after the edge pop and compare.
  task automatic cyc(input bit lv, input logic [26:0] lt, input bit fv,
                     input logic [26:0] ft, input logic [43:0] fd,
                     input bit fl, input logic [2:0] ri);
    exp_t e, o;
    int   slot, hit;
    bit   acc, grow;
    lookup_valid_i = lv; lookup_tag_i = lt;
    fill_valid_i = fv; fill_tag_i = ft; fill_data_i = fd;
    flush_i = fl; replacement_idx_i = ri;

    acc  = fv && !fl;
    slot = -1;
    grow = 0;
    for (int i = 0; i < 8; i++)
      if (slot < 0 && m_valid[i] && m_tag[i] == ft) slot = i;
    if (slot < 0)
      for (int i = 0; i < 8; i++)
        if (slot < 0 && !m_valid[i]) begin slot = i; grow = 1; end
    if (slot < 0) slot = int'(ri);

    hit = -1;
    if (lv && !fl && !(acc && ft == lt))
      for (int i = 0; i < 8; i++)
        if (hit < 0 && m_valid[i] && m_tag[i] == lt) hit = i;

    e.rv = lv;
    e.rh = (hit >= 0);
    e.rd = '0;
    if (hit >= 0) e.rd = m_data[hit];
    if (hit >= 0)      begin e.ah = 1; m_aidx = 3'(hit);  end
    else if (acc)      begin e.ah = 1; m_aidx = 3'(slot); end
    else               e.ah = 0;
    e.ai = m_aidx;

    if (fl) begin
      for (int i = 0; i < 8; i++) m_valid[i] = 0;
      m_count = 0;
    end else if (acc) begin
      m_valid[slot] = 1; m_tag[slot] = ft; m_data[slot] = fd;
      if (grow) m_count++;
    end
    e.cnt = 4'(m_count);
    sb.push_back(e);

    #1;
    chk("fill_ready", 64'(fill_ready_o), 64'(!fl));
    @(posedge clk_i); #1;
    o = sb.pop_front();
    chk("resp_valid", 64'(resp_valid_o), 64'(o.rv));
    chk("resp_hit",   64'(resp_hit_o),   64'(o.rh));
    chk("resp_data",  64'(resp_data_o),  64'(o.rd));
    chk("access_hit", 64'(access_hit_o), 64'(o.ah));
    chk("access_idx", 64'(access_idx_o), 64'(o.ai));
    chk("count",      64'(count_o),      64'(o.cnt));
  endtask

  task automatic idle_all();
    lookup_valid_i = 0; fill_valid_i = 0; flush_i = 0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_resp_valid", 64'(resp_valid_o), 0);
    chk("rst_resp_hit",   64'(resp_hit_o), 0);
    chk("rst_resp_data",  64'(resp_data_o), 0);
    chk("rst_access_hit", 64'(access_hit_o), 0);
    chk("rst_access_idx", 64'(access_idx_o), 0);
    chk("rst_count",      64'(count_o), 0);
    rst_i = 0;

    // Lookup into an empty store.
    cyc(1, 27'h1, 0, 0, 0, 0, 0);

    // Back-to-back fills populate slots 0..7 in order.
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 27'h10 + 27'(i), 44'hA0 + 44'(i), 0, 3'(7 - i));
      chk("fill_order_idx", 64'(access_idx_o), 64'(i));
    end
    chk("count_full", 64'(count_o), 8);
    cyc(1, 27'h15, 0, 0, 0, 0, 0);
    chk("hit_15_data", 64'(resp_data_o), 64'hA5);

    // Full store: replacement index picks the victim.
    cyc(0, 0, 1, 27'h20, 44'hB0, 0, 3'd3);
    chk("repl_idx", 64'(access_idx_o), 3);
    cyc(1, 27'h13, 0, 0, 0, 0, 0);
    chk("evicted_miss", 64'(resp_hit_o), 0);
    cyc(1, 27'h20, 0, 0, 0, 0, 0);
    chk("new_hit_data", 64'(resp_data_o), 64'hB0);

    // Duplicate tag rewrites its own slot.
    cyc(0, 0, 1, 27'h15, 44'hC5, 0, 3'd0);
    chk("dup_idx", 64'(access_idx_o), 5);
    cyc(1, 27'h15, 0, 0, 0, 0, 0);
    chk("dup_data", 64'(resp_data_o), 64'hC5);

    // Lookup hit and fill in one cycle: lookup touch wins.
    cyc(1, 27'h12, 1, 27'h30, 44'hD0, 0, 3'd7);
    chk("both_idx", 64'(access_idx_o), 2);
    cyc(1, 27'h30, 0, 0, 0, 0, 0);
    chk("fill30_hit", 64'(resp_hit_o), 1);

    // Lookup of the tag being filled this cycle misses, then hits.
    cyc(1, 27'h44, 1, 27'h44, 44'hE4, 0, 3'd1);
    chk("samecyc_miss", 64'(resp_hit_o), 0);
    cyc(1, 27'h44, 0, 0, 0, 0, 0);

    // Flush blocks the fill and the lookup; the held fill lands in slot 0.
    cyc(1, 27'h11, 1, 27'h40, 44'hF0, 1, 3'd6);
    chk("flush_count", 64'(count_o), 0);
    cyc(0, 0, 1, 27'h40, 44'hF0, 0, 3'd6);
    chk("refill_idx", 64'(access_idx_o), 0);
    cyc(1, 27'h40, 0, 0, 0, 0, 0);

    // Idle cycle: touch drops, index holds.
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Random traffic over a small tag space to force hits, dups and evictions.
    for (int n = 0; n < 300; n++)
      cyc($urandom_range(0, 1), 27'h100 + 27'($urandom_range(0, 11)),
          $urandom_range(0, 1), 27'h100 + 27'($urandom_range(0, 11)),
          44'($urandom), ($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)));

    // Asynchronous reset with a hit response on the outputs.
    cyc(0, 0, 1, 27'h55, 44'h55, 0, 3'd2);
    lookup_valid_i = 1; lookup_tag_i = 27'h55; fill_valid_i = 0; flush_i = 0;
    @(posedge clk_i); #1;
    chk("pre_rst_hit", 64'(resp_hit_o), 1);
    idle_all();
    #2 rst_i = 1;
    #1;
    chk("async_rst_valid", 64'(resp_valid_o), 0);
    chk("async_rst_hit",   64'(resp_hit_o), 0);
    chk("async_rst_data",  64'(resp_data_o), 0);
    chk("async_rst_ah",    64'(access_hit_o), 0);
    chk("async_rst_count", 64'(count_o), 0);
    @(posedge clk_i); #1;
    rst_i = 0;
    model_reset();
    cyc(1, 27'h55, 0, 0, 0, 0, 0);
    chk("post_rst_miss", 64'(resp_hit_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fa_tag_store.md
Name: fa_tag_store

Overview:
Fully-associative tag/data store. It is the storage-side partner of the pseudo-LRU replacement tracker.
- Performs registered lookups against ENTRIES tag/data slots.
- Reports each lookup hit and its slot index to the tracker.
- Consumes the tracker's replacement index to choose a victim on fill.
- Used as the lookup array of small TLBs and PTW caches in the MMU.

Parameters:
ENTRIES, 8, number of slots; power of two, >= 2
TAG_W, 27, tag width in bits
DATA_W, 44, payload width in bits

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous active-high reset
lookup_valid_i  in  1  lookup request this cycle
lookup_tag_i  in  TAG_W  tag to search
resp_valid_o  out  1  lookup response valid (one cycle after request)
resp_hit_o  out  1  response is a hit
resp_data_o  out  DATA_W  payload of hit slot; 0 on miss
fill_valid_i  in  1  fill request
fill_ready_o  out  1  fill accepted when fill_valid_i & fill_ready_o
fill_tag_i  in  TAG_W  fill tag
fill_data_i  in  DATA_W  fill payload
flush_i  in  1  invalidate all slots
access_hit_o  out  1  to tracker: touch slot access_idx_o this cycle
access_idx_o  out  $clog2(ENTRIES)  to tracker: slot touched
replacement_idx_i  in  $clog2(ENTRIES)  from tracker: victim slot
count_o  out  $clog2(ENTRIES)+1  number of valid slots

Behaviour:
Reset (rst_i high, asynchronous):
- All valid bits = 0; resp_valid_o = 0; resp_hit_o = 0; resp_data_o = 0.
- access_hit_o = 0; access_idx_o = 0; count_o = 0.
- Tag/data arrays are not reset.
- Reset asserted mid-operation discards any in-flight response and any pending fill touch.

Lookup:
- Request in cycle N compares lookup_tag_i against all valid slots using state as it stands at the start of cycle N.
- Result is registered and presented in cycle N+1: resp_valid_o = 1, resp_hit_o, resp_data_o.
- No request in cycle N -> resp_valid_o = 0, resp_hit_o = 0, resp_data_o = 0 in cycle N+1.
- At most one slot can match, because fill de-duplicates. The encoder takes the lowest matching index regardless.
- A lookup in the same cycle as flush_i responds as a miss.
- A lookup in the same cycle as an accepted fill of the same tag responds as a miss; the new entry is visible from cycle N+1.

Fill:
- fill_ready_o = ~flush_i (combinational).
- An accepted fill writes its slot at the end of the acceptance cycle.
- Victim selection, in priority order:
  1. A valid slot whose tag equals fill_tag_i (overwrite, no duplicate).
  2. Otherwise the lowest-index invalid slot.
  3. Otherwise replacement_idx_i.
- count_o increments by 1 only in case 2; saturates at ENTRIES.

Tracker interface (registered, cycle N+1):
- Lookup hit in cycle N -> access_hit_o = 1, access_idx_o = hit slot. Coincident with resp_hit_o.
- Accepted fill in cycle N and no lookup hit in cycle N -> access_hit_o = 1, access_idx_o = filled slot. The new entry becomes MRU.
- Both in cycle N -> the lookup hit wins and the fill touch is dropped.
- Neither -> access_hit_o = 0; access_idx_o holds its previous value.

Flush:
- flush_i clears all valid bits at the end of the cycle; count_o = 0 the next cycle.
- A fill presented in a flush cycle is not accepted and must be held by the source.
- A response already registered before the flush cycle is still delivered unchanged.
- flush_i does not reset the tracker; the tracker is driven only by the access port.

Test Plan:
- Reset, then lookup tag 0x1 -> next cycle resp_valid_o=1, resp_hit_o=0, resp_data_o=0, access_hit_o=0, count_o=0.
- Fill tags 0x10..0x17, data 0xA0..0xA7, back-to-back -> slots 0..7 used in order; access_idx_o 0..7 one cycle later; count_o reaches 8. Lookup 0x15 -> hit, data 0xA5, access_idx_o=5.
- Full store, replacement_idx_i=3, fill tag 0x20 data 0xB0 -> slot 3 overwritten; lookup 0x13 misses; lookup 0x20 hits with data 0xB0; count_o stays 8.
- Fill tag 0x15 data 0xC5 while 0x15 is valid in slot 5 -> slot 5 rewritten regardless of replacement_idx_i; lookup 0x15 returns 0xC5; count_o unchanged.
- Same cycle: lookup 0x12 (hit, slot 2) and accepted fill of 0x30 to slot 7 -> next cycle access_hit_o=1, access_idx_o=2, no touch for slot 7; lookup 0x30 in the following cycle hits.
- flush_i with fill_valid_i and lookup 0x11 in the same cycle -> fill_ready_o=0; lookup responds miss; count_o=0 next cycle; the held fill is accepted the cycle after into slot 0.
